// File: rtl/lockin_pkg.sv
// lockin_pkg: shared constants, state encoding and helpers for the lock-in
// boxcar low-pass filter.
//   LOCKIN_IN_W       sample width (signed)
//   LOCKIN_MAX_LOG2N  largest decimation exponent
//   LOCKIN_ACC_W      accumulator width; holds the sum of 2^MAX_LOG2N samples exactly
//   state_t           ST_IDLE (no window open) / ST_ACCUM (window in progress)
//   clamp_log2n       limits a requested exponent to the supported maximum
package lockin_pkg;

  localparam int LOCKIN_IN_W      = 32;
  localparam int LOCKIN_MAX_LOG2N = 16;
  localparam int LOCKIN_ACC_W     = LOCKIN_IN_W + LOCKIN_MAX_LOG2N;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  function automatic logic [4:0] clamp_log2n(input logic [4:0] l, input int unsigned max_l);
    logic [4:0] lim;
    lim = 5'(max_l);
    return (l > lim) ? lim : l;
  endfunction

endpackage

// File: rtl/lockin_iir1.sv
// lockin_iir1: one-pole IIR smoother y <= y + ((x - y) >>> k) applied once per
// valid input sample. y carries (2^K_W - 1) fractional bits so small steps are
// not lost; the output is the integer part (floor) of y.
// Only instantiated when LOCKIN_IIR_EN is defined.
// Ports:
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset; clears y
//   k_in         smoothing shift; 0 makes y follow x exactly
//   x_in         signed input sample
//   x_valid_in   x_in is a new sample this cycle
//   y_out        signed smoothed output, held between updates
//   y_valid_out  1-cycle strobe, y_out updated this cycle
module lockin_iir1 #(
  parameter int IN_W = 32,
  parameter int K_W  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [K_W-1:0]         k_in,
  input  logic signed [IN_W-1:0] x_in,
  input  logic                   x_valid_in,
  output logic signed [IN_W-1:0] y_out,
  output logic                   y_valid_out
);

  localparam int FRAC_W = (1 << K_W) - 1;
  localparam int Y_W    = IN_W + FRAC_W;

  logic signed [Y_W-1:0] y_p2;
  logic                  vld_p2;

  // One guard bit on the difference; the update is a convex step toward x,
  // so the result always fits back into Y_W bits.
  function automatic logic signed [Y_W-1:0] iir_update(
    input logic signed [Y_W-1:0]  y,
    input logic signed [IN_W-1:0] x,
    input logic [K_W-1:0]         k
  );
    logic signed [Y_W:0] d;
    logic signed [Y_W:0] s;
    d = {x[IN_W-1], x, {FRAC_W{1'b0}}} - {y[Y_W-1], y};
    s = d >>> k;
    return Y_W'({y[Y_W-1], y} + s);
  endfunction

  // Stage p2: smoothed value register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_p2   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= x_valid_in;
      if (x_valid_in) begin
        y_p2 <= iir_update(y_p2, x_in, k_in);
      end
    end
  end

  assign y_out       = y_p2[Y_W-1:FRAC_W];
  assign y_valid_out = vld_p2;

endmodule

// File: rtl/lockin_boxcar_lpf.sv
// lockin_boxcar_lpf: decimating accumulate-and-dump low-pass filter for the
// lock-in mixer product. Sums 2^L consecutive samples and emits their mean
// (arithmetic shift, floor toward -inf) with a 1-cycle valid strobe. Windows
// run back to back while en_in stays high; dropping en_in discards the window.
// Optional macro LOCKIN_IIR_EN adds a one-pole IIR smoother (lockin_iir1)
// after the mean, adds the iir_k_in port and one clock of latency.
// Ports:
//   clk_in      clock, rising edge
//   rst_n_in    asynchronous active-low reset
//   en_in       1 = accept a sample this clock; 0 = abort window, go idle
//   log2n_in    requested exponent L (clamped to MAX_LOG2N), latched per window
//   iir_k_in    IIR shift k (LOCKIN_IIR_EN only)
//   signal_in   signed mixer sample
//   signal_out  signed filtered output, held between strobes
//   valid_out   1-cycle strobe, signal_out new this cycle
//   busy_out    high while a window is open
module lockin_boxcar_lpf
  import lockin_pkg::*;
#(
  parameter int IN_W      = LOCKIN_IN_W,
  parameter int MAX_LOG2N = LOCKIN_MAX_LOG2N
`ifdef LOCKIN_IIR_EN
  , parameter int IIR_K_W = 4
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   en_in,
  input  logic [4:0]             log2n_in,
`ifdef LOCKIN_IIR_EN
  input  logic [IIR_K_W-1:0]     iir_k_in,
`endif
  input  logic signed [IN_W-1:0] signal_in,
  output logic signed [IN_W-1:0] signal_out,
  output logic                   valid_out,
  output logic                   busy_out
);

  localparam int ACC_W = IN_W + MAX_LOG2N;
  localparam int CNT_W = MAX_LOG2N;

  state_t                  state_p0, state_nxt;
  logic signed [ACC_W-1:0] acc_p0, acc_nxt, sum;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt, cnt_last;
  logic [4:0]              l_lat_p0, l_lat_nxt, l_new, shamt;
  logic                    last;
  logic signed [IN_W-1:0]  mean_nxt, mean_p1;
  logic                    vld_p1;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  // The mean of in-range samples is itself in range, so truncating the
  // shifted sum back to IN_W bits never wraps.
  function automatic logic signed [IN_W-1:0] window_mean(
    input logic signed [ACC_W-1:0] s,
    input logic [4:0]              l
  );
    return IN_W'(s >>> l);
  endfunction

  assign l_new = clamp_log2n(log2n_in, MAX_LOG2N);
  // cnt counts samples already in acc; the window closes on sample 2^L.
  assign cnt_last = ~({CNT_W{1'b1}} << l_lat_p0);

  always_comb begin
    state_nxt = state_p0;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt_p0;
    l_lat_nxt = l_lat_p0;
    last      = 1'b0;
    shamt     = l_lat_p0;
    sum       = sext(signal_in);
    case (state_p0)
      ST_IDLE: begin
        if (en_in) begin
          state_nxt = ST_ACCUM;
          l_lat_nxt = l_new;
          shamt     = l_new;
          if (l_new == 5'd0) begin
            last    = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
          end else begin
            acc_nxt = sum;
            cnt_nxt = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (!en_in) begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          sum = acc_p0 + sext(signal_in);
          if (cnt_p0 == cnt_last) begin
            // Close this window and open the next one in the same clock.
            last      = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            l_lat_nxt = l_new;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt_p0 + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    mean_nxt = window_mean(sum, shamt);
  end

  // Stage p0: window state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_p0 <= ST_IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      l_lat_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      acc_p0   <= acc_nxt;
      cnt_p0   <= cnt_nxt;
      l_lat_p0 <= l_lat_nxt;
    end
  end

  // Stage p1: window mean
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mean_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= last;
      if (last) begin
        mean_p1 <= mean_nxt;
      end
    end
  end

  assign busy_out = (state_p0 == ST_ACCUM);

`ifdef LOCKIN_IIR_EN
  lockin_iir1 #(
    .IN_W (IN_W),
    .K_W  (IIR_K_W)
  ) u_iir (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .k_in        (iir_k_in),
    .x_in        (mean_p1),
    .x_valid_in  (vld_p1),
    .y_out       (signal_out),
    .y_valid_out (valid_out)
  );
`else
  assign signal_out = mean_p1;
  assign valid_out  = vld_p1;
`endif

endmodule

// File: tb/tb_lockin_boxcar_lpf.sv
// tb_lockin_boxcar_lpf: self-checking bench for lockin_boxcar_lpf.
// Directed windows plus randomized traffic, compared every clock against a
// reference built from window sums and floor division (and, with
// LOCKIN_IIR_EN, a fixed-point smoother with 15 fractional bits).
module tb_lockin_boxcar_lpf;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic [4:0]         log2n = '0;
  logic signed [31:0] sig_in = '0;
  logic signed [31:0] sig_out;
  logic               vld;
  logic               busy;
`ifdef LOCKIN_IIR_EN
  logic [3:0]         k = '0;
`endif

  always #5 clk = ~clk;

  lockin_boxcar_lpf dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .en_in      (en),
    .log2n_in   (log2n),
`ifdef LOCKIN_IIR_EN
    .iir_k_in   (k),
`endif
    .signal_in  (sig_in),
    .signal_out (sig_out),
    .valid_out  (vld),
    .busy_out   (busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  int k_cur   = 0;

  // Reference state
  bit     m_active;
  int     m_L;
  longint m_cnt, m_sum;
  longint e_mean, e_out, y_fx;
  bit     e_mvld, e_vld;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp_l(input int l);
    return (l > 16) ? 16 : l;
  endfunction

  task automatic model_reset();
    m_active = 0; m_L = 0; m_cnt = 0; m_sum = 0;
    e_mean = 0; e_mvld = 0; e_out = 0; e_vld = 0; y_fx = 0;
  endtask

  task automatic model_clock(input bit e, input int l, input int s);
    longint mean;
    bit     mv;
    mean = 0;
    mv   = 0;
    if (!e) begin
      m_active = 0; m_cnt = 0; m_sum = 0;
    end else begin
      if (!m_active) begin
        m_active = 1; m_L = clamp_l(l); m_cnt = 0; m_sum = 0;
      end
      m_sum = m_sum + longint'(s);
      m_cnt = m_cnt + 1;
      if (m_cnt == (longint'(1) << m_L)) begin
        mean  = floor_div(m_sum, longint'(1) << m_L);
        mv    = 1;
        m_cnt = 0;
        m_sum = 0;
        m_L   = clamp_l(l);
      end
    end
`ifdef LOCKIN_IIR_EN
    e_vld = e_mvld;
    if (e_mvld) begin
      y_fx  = y_fx + floor_div(e_mean * 32768 - y_fx, longint'(1) << k_cur);
      e_out = floor_div(y_fx, 32768);
    end
`else
    e_vld = mv;
    if (mv) e_out = mean;
`endif
    e_mean = mean;
    e_mvld = mv;
  endtask

  task automatic step(input bit e, input int l, input int s);
    en     = e;
    log2n  = 5'(l);
    sig_in = s;
`ifdef LOCKIN_IIR_EN
    k = 4'(k_cur);
`endif
    @(posedge clk);
    model_clock(e, l, s);
    #1;
    chk("valid", longint'(vld), longint'(e_vld));
    chk("out", longint'(sig_out), e_out);
    chk("busy", longint'(busy), longint'(m_active));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out", longint'(sig_out), 0);
    chk("rst_valid", longint'(vld), 0);
    chk("rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pulse_reset();

    // L=2, constant 1000: strobe every 4th sample
    repeat (12) step(1, 2, 1000);
`ifndef LOCKIN_IIR_EN
    chk("l2_mean", longint'(sig_out), 1000);
    chk("l2_valid", longint'(vld), 1);
`endif

    // L=0 pass-through
    step(0, 0, 0);
    step(1, 0, -5);
`ifndef LOCKIN_IIR_EN
    chk("l0_neg", longint'(sig_out), -5);
`endif
    step(1, 0, 7);
`ifndef LOCKIN_IIR_EN
    chk("l0_pos", longint'(sig_out), 7);
`endif
    step(1, 0, int'(32'h7FFFFFFF));
`ifndef LOCKIN_IIR_EN
    chk("l0_max", longint'(sig_out), 64'sd2147483647);
    chk("l0_valid", longint'(vld), 1);
`endif

    // L=1 floor behaviour
    step(0, 1, 0);
    step(1, 1, -1);
    step(1, 1, 0);
`ifndef LOCKIN_IIR_EN
    chk("l1_floor", longint'(sig_out), -1);
`endif
    step(1, 1, 3);
    step(1, 1, 4);
`ifndef LOCKIN_IIR_EN
    chk("l1_mean", longint'(sig_out), 3);
`endif

    // log2n change mid-window applies from the next window only
    step(0, 2, 0);
    step(1, 2, 10);
    step(1, 2, 20);
    step(1, 3, 30);
    step(1, 3, 40);
`ifndef LOCKIN_IIR_EN
    chk("lchg_first", longint'(sig_out), 25);
`endif
    for (int i = 1; i <= 8; i++) step(1, 3, i);
`ifndef LOCKIN_IIR_EN
    chk("lchg_second", longint'(sig_out), 4);
`endif

    // Abort after 3 samples, then a fresh 4-sample window
    step(0, 2, 0);
    repeat (3) step(1, 2, 100);
    step(0, 2, 0);
    step(0, 2, 0);
    chk("abort_novalid", longint'(vld), 0);
    repeat (4) step(1, 2, -8);
`ifndef LOCKIN_IIR_EN
    chk("after_abort", longint'(sig_out), -8);
`endif

    // Asynchronous reset mid-window, then a clean window
    repeat (2) step(1, 2, 5);
    pulse_reset();
    repeat (4) step(1, 2, 12);
`ifndef LOCKIN_IIR_EN
    chk("after_rst", longint'(sig_out), 12);
`endif

    // Full-scale windows: positive max at L=12, negative min at L=16
    // (requested as 31 to exercise the clamp)
    step(0, 12, 0);
    repeat (4096) step(1, 12, int'(32'h7FFFFFFF));
`ifndef LOCKIN_IIR_EN
    chk("l12_max", longint'(sig_out), 64'sd2147483647);
`endif
    step(0, 31, 0);
    repeat (65536) step(1, 31, int'(32'h80000000));
`ifndef LOCKIN_IIR_EN
    chk("l16_min", longint'(sig_out), -64'sd2147483648);
`endif
    step(0, 0, 0);

    // Randomized traffic
    begin
      int lr;
      lr = 1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 7) == 0) lr = int'($urandom_range(0, 3));
`ifdef LOCKIN_IIR_EN
        if ($urandom_range(0, 15) == 0) k_cur = int'($urandom_range(0, 4));
`endif
        step(($urandom_range(0, 15) != 0), lr, int'($urandom));
      end
    end

`ifdef LOCKIN_IIR_EN
    // Smoother step response, k=1 then k=0
    step(0, 0, 0);
    pulse_reset();
    k_cur = 1;
    repeat (2) step(1, 0, 0);
    step(1, 0, 1024);
    step(1, 0, 1024);
    chk("iir_k1_a", longint'(sig_out), 512);
    step(1, 0, 1024);
    chk("iir_k1_b", longint'(sig_out), 768);
    step(1, 0, 1024);
    chk("iir_k1_c", longint'(sig_out), 896);
    step(1, 0, 1024);
    chk("iir_k1_d", longint'(sig_out), 960);
    step(0, 0, 0);
    pulse_reset();
    k_cur = 0;
    step(1, 0, 1024);
    step(1, 0, 1024);
    chk("iir_k0", longint'(sig_out), 1024);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
